// File: rtl/c64_rom_pkg.sv
// Shared constants and types for the C64 ROM loader.
// The CHECK state only exists when ROM_LOADER_CHECKSUM_EN is defined.
package c64_rom_pkg;

    localparam int unsigned BYTE_WIDTH = 8;
    localparam int unsigned LEN_WIDTH  = 16;
    localparam int unsigned NUM_BANKS  = 3;

    localparam logic [BYTE_WIDTH-1:0] BANK_BASIC   = 8'd0;
    localparam logic [BYTE_WIDTH-1:0] BANK_KERNAL  = 8'd1;
    localparam logic [BYTE_WIDTH-1:0] BANK_CHARGEN = 8'd2;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StLenLo  = 3'd1,
        StLenHi  = 3'd2,
        StData   = 3'd3,
`ifdef ROM_LOADER_CHECKSUM_EN
        StCheck  = 3'd4,
`endif
        StFinish = 3'd5
    } loader_state_e;

    function automatic logic [NUM_BANKS-1:0] bank_onehot(input logic [1:0] id);
        return NUM_BANKS'(1) << id;
    endfunction

endpackage

// File: rtl/rom_loader.sv
// Streams ROM images (bank, len_lo, len_hi, data[, checksum]) into the C64 ROM write ports.
// Define ROM_LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte per image.
module rom_loader
    import c64_rom_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 13
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [BYTE_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [BYTE_WIDTH-1:0] wr_data,
    output logic                  wr_en,
    output logic [NUM_BANKS-1:0]  wr_bank,
    output logic                  cpu_hold,
    output logic                  done,
    output logic                  error
);

    localparam logic [LEN_WIDTH:0] DEPTH_LEN = (LEN_WIDTH + 1)'(1 << ADDR_WIDTH);

    loader_state_e          state_q, state_d;
    logic                   fail_q, fail_d;
    logic                   in_ready_q;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [ADDR_WIDTH-1:0]  cnt_q;
`ifdef ROM_LOADER_CHECKSUM_EN
    logic [BYTE_WIDTH-1:0]  sum_q;
`endif

    logic                   xfer;
    logic [LEN_WIDTH-1:0]   full_len;
    logic                   len_bad;
    logic                   last_byte;

    assign in_ready  = in_ready_q;
    assign xfer      = in_valid & in_ready_q;
    assign full_len  = {in_data, len_q[7:0]};
    assign len_bad   = (full_len == '0) || ({1'b0, full_len} > DEPTH_LEN);
    assign last_byte = (LEN_WIDTH'(cnt_q) + LEN_WIDTH'(1)) == len_q;

    always_comb begin
        state_d = state_q;
        fail_d  = fail_q;
        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    if (in_data > BANK_CHARGEN) begin
                        fail_d  = 1'b1;
                        state_d = StFinish;
                    end else begin
                        fail_d  = 1'b0;
                        state_d = StLenLo;
                    end
                end
            end
            StLenLo: begin
                if (xfer) begin
                    state_d = StLenHi;
                end
            end
            StLenHi: begin
                if (xfer) begin
                    if (len_bad) begin
                        fail_d  = 1'b1;
                        state_d = StFinish;
                    end else begin
                        state_d = StData;
                    end
                end
            end
            StData: begin
                if (xfer && last_byte) begin
`ifdef ROM_LOADER_CHECKSUM_EN
                    state_d = StCheck;
`else
                    fail_d  = 1'b0;
                    state_d = StFinish;
`endif
                end
            end
`ifdef ROM_LOADER_CHECKSUM_EN
            StCheck: begin
                if (xfer) begin
                    fail_d  = (in_data != sum_q);
                    state_d = StFinish;
                end
            end
`endif
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            fail_q     <= 1'b0;
            in_ready_q <= 1'b0;
            len_q      <= '0;
            cnt_q      <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            wr_bank    <= '0;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef ROM_LOADER_CHECKSUM_EN
            sum_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            fail_q     <= fail_d;
            // Registered so FINISH sees in_ready low without a combinational path.
            in_ready_q <= (state_d != StFinish);
            wr_en      <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (xfer) begin
                        done     <= 1'b0;
                        error    <= 1'b0;
                        cpu_hold <= 1'b1;
                        if (in_data <= BANK_CHARGEN) begin
                            wr_bank <= bank_onehot(in_data[1:0]);
                        end
                    end
                end
                StLenLo: begin
                    if (xfer) begin
                        len_q[7:0] <= in_data;
                    end
                end
                StLenHi: begin
                    if (xfer) begin
                        len_q[15:8] <= in_data;
                        cnt_q       <= '0;
`ifdef ROM_LOADER_CHECKSUM_EN
                        sum_q       <= '0;
`endif
                    end
                end
                StData: begin
                    if (xfer) begin
                        wr_en   <= 1'b1;
                        wr_addr <= cnt_q;
                        wr_data <= in_data;
                        cnt_q   <= cnt_q + ADDR_WIDTH'(1);
`ifdef ROM_LOADER_CHECKSUM_EN
                        sum_q   <= sum_q + in_data;
`endif
                    end
                end
`ifdef ROM_LOADER_CHECKSUM_EN
                StCheck: begin
                end
`endif
                StFinish: begin
                    // A rejected image keeps the CPU held so it never runs corrupt code.
                    if (fail_q) begin
                        error <= 1'b1;
                    end else begin
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// Scoreboard bench for rom_loader; follows ROM_LOADER_CHECKSUM_EN like the RTL.
module tb_rom_loader;

    localparam int unsigned AW = 13;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic          wr_en;
    logic [2:0]    wr_bank;
    logic          cpu_hold;
    logic          done;
    logic          error;

    rom_loader #(.ADDR_WIDTH(AW)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_en    (wr_en),
        .wr_bank  (wr_bank),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    bank;
        logic [AW-1:0] addr;
        logic [7:0]    data;
        int            cyc;
    } wr_t;

    wr_t        sb[$];
    wr_t        mon_exp;
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         writes_seen = 0;
    logic [2:0] cur_bank = 3'b000;
    int         cur_addr = 0;
    logic [7:0] cur_sum = 8'h00;

    always @(posedge clk) cyc <= cyc + 1;

    // Write monitor: every strobe must match the oldest outstanding data transfer.
    always @(negedge clk) begin
        if (done && error) begin
            checks++;
            errors++;
            $display("FAIL status_exclusive done=%b error=%b required not both", done, error);
        end
        if (wr_en) begin
            writes_seen++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write bank=%b addr=%h data=%h required no write",
                         wr_bank, wr_addr, wr_data);
            end else begin
                mon_exp = sb.pop_front();
                if (wr_bank !== mon_exp.bank || wr_addr !== mon_exp.addr ||
                    wr_data !== mon_exp.data || cyc !== mon_exp.cyc) begin
                    errors++;
                    $display("FAIL write bank=%b addr=%h data=%h cyc=%0d required %b %h %h %0d",
                             wr_bank, wr_addr, wr_data, cyc,
                             mon_exp.bank, mon_exp.addr, mon_exp.data, mon_exp.cyc);
                end
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    // Called just after a posedge; returns just after the edge that took the byte.
    task automatic send_byte(input logic [7:0] b, input bit is_data);
        int guard;
        bit sent;
        guard = 0;
        sent = 0;
        in_data = b;
        in_valid = 1'b1;
        while (!sent) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                if (is_data) begin
                    sb.push_back('{cur_bank, AW'(cur_addr), b, cyc + 1});
                    cur_addr++;
                    cur_sum = cur_sum + b;
                end
                sent = 1;
            end else begin
                guard++;
                if (guard > 50) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout byte=%h in_ready=%b required 1", b, in_ready);
                    sent = 1;
                end
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic send_stalled(input logic [7:0] b);
        repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
        end
        send_byte(b, 1'b1);
    endtask

    task automatic send_header(input logic [7:0] id, input logic [15:0] len);
        if (id < 8'd3) cur_bank = 3'b001 << id[1:0];
        cur_addr = 0;
        cur_sum = 8'h00;
        send_byte(id, 1'b0);
        if (id < 8'd3) begin
            send_byte(len[7:0], 1'b0);
            send_byte(len[15:8], 1'b0);
        end
    endtask

    task automatic send_checksum(input logic [7:0] b);
`ifdef ROM_LOADER_CHECKSUM_EN
        send_byte(b, 1'b0);
`else
        if (b === 8'hxx) $display("unreachable");
`endif
    endtask

    // Checks the FINISH cycle and the status in the cycle after it.
    task automatic check_finish(input bit ok, input string name);
        logic [3:0] exp;
        @(negedge clk);
        checks++;
        if ({in_ready, cpu_hold, done, error} !== 4'b0100) begin
            errors++;
            $display("FAIL %s_finish {rdy,hold,done,err}=%b required 0100", name,
                     {in_ready, cpu_hold, done, error});
        end
        @(negedge clk);
        exp = {1'b1, !ok, ok, !ok};
        checks++;
        if ({in_ready, cpu_hold, done, error} !== exp) begin
            errors++;
            $display("FAIL %s_status {rdy,hold,done,err}=%b required %b", name,
                     {in_ready, cpu_hold, done, error}, exp);
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_pending writes_left=%0d required 0", name, sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, wr_en, cpu_hold, done, error} !== 5'b00100) begin
            errors++;
            $display("FAIL reset_ctrl {rdy,wen,hold,done,err}=%b required 00100",
                     {in_ready, wr_en, cpu_hold, done, error});
        end
        checks++;
        if ({wr_addr, wr_data, wr_bank} !== '0) begin
            errors++;
            $display("FAIL reset_data addr=%h data=%h bank=%b required 0 0 000",
                     wr_addr, wr_data, wr_bank);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_full_kernal();
        int start;
        start = writes_seen;
        send_header(8'h01, 16'h2000);
        for (int i = 0; i < 8192; i++) send_byte(8'(i & 8'hFF), 1'b1);
        send_checksum(8'h00);
        check_finish(1'b1, "kernal");
        checks++;
        if (writes_seen - start !== 8192) begin
            errors++;
            $display("FAIL kernal_count writes=%0d required 8192", writes_seen - start);
        end
    endtask

    task automatic test_bad_bank();
        int start;
        start = writes_seen;
        send_header(8'h05, 16'h0000);
        check_finish(1'b0, "bad_bank");
        checks++;
        if (writes_seen !== start) begin
            errors++;
            $display("FAIL bad_bank_writes writes=%0d required %0d", writes_seen, start);
        end
        send_header(8'h00, 16'h0002);
        send_byte(8'hAA, 1'b1);
        send_byte(8'h55, 1'b1);
        send_checksum(cur_sum);
        check_finish(1'b1, "after_bad_bank");
    endtask

    task automatic test_bad_len();
        send_header(8'h00, 16'h0000);
        check_finish(1'b0, "len_zero");
        send_header(8'h00, 16'h2001);
        check_finish(1'b0, "len_over");
    endtask

    task automatic test_checksum();
        send_header(8'h02, 16'h0004);
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
`ifdef ROM_LOADER_CHECKSUM_EN
        send_checksum(8'h0B);
        check_finish(1'b0, "csum_bad");
        send_header(8'h02, 16'h0004);
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
        send_checksum(8'h0A);
`endif
        check_finish(1'b1, "csum_good");
    endtask

    task automatic test_stall();
        send_header(8'h00, 16'h0040);
        for (int i = 0; i < 64; i++) send_stalled(8'($urandom_range(0, 255)));
        send_checksum(cur_sum);
        check_finish(1'b1, "stall");
    endtask

    task automatic test_reset_mid();
        send_header(8'h00, 16'h0100);
        for (int i = 0; i < 100; i++) send_byte(8'(i + 7), 1'b1);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({wr_en, cpu_hold, in_ready, done} !== 4'b0100) begin
            errors++;
            $display("FAIL reset_mid {wen,hold,rdy,done}=%b required 0100",
                     {wr_en, cpu_hold, in_ready, done});
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        send_header(8'h01, 16'h0004);
        for (int i = 0; i < 4; i++) send_byte(8'(8'hC0 + i), 1'b1);
        send_checksum(cur_sum);
        check_finish(1'b1, "restart");
    endtask

    initial begin
        test_reset();
        test_full_kernal();
        test_bad_bank();
        test_bad_len();
        test_checksum();
        test_stall();
        test_reset_mid();
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rom_loader.md
# rom_loader

Byte-stream loader that fills the C64 system ROMs (BASIC, KERNAL, CHARGEN) at power-up, so the ROM images come from an external source (UART or SD bridge) instead of fixed memory-init files. It sits directly upstream of the ROM arrays. It consumes a valid/ready byte stream, parses a small header, and issues write strobes into the selected ROM bank. It holds the CPU in reset until an image has loaded cleanly.

## Interface
- ADDR_WIDTH, 13: ROM address width; bank depth is 1<<ADDR_WIDTH.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_data  in  8  stream byte.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts the byte this cycle (a transfer is in_valid & in_ready).
- wr_addr  out  ADDR_WIDTH  ROM write address.
- wr_data  out  8  ROM write data.
- wr_en  out  1  one-cycle write strobe.
- wr_bank  out  3  one-hot bank select: [0] BASIC, [1] KERNAL, [2] CHARGEN.
- cpu_hold  out  1  keeps the CPU/VIC in reset while high.
- done  out  1  sticky: last image loaded successfully.
- error  out  1  sticky: last image was rejected.

## Operation
- Stream format: bank id (0/1/2), len_lo, len_hi, then len data bytes, then an optional checksum byte (see Configuration).
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, CHECK, FINISH.
- IDLE:
  - Accepts the bank byte.
  - Clears done and error, and sets cpu_hold.
  - Bank id > 2 -> FINISH with error.
  - Otherwise latches the one-hot bank and goes to LEN_LO.
- LEN_LO: latches len[7:0] -> LEN_HI.
- LEN_HI:
  - Latches len[15:8].
  - len == 0 or len > (1<<ADDR_WIDTH) -> FINISH with error.
  - Otherwise clears the address counter -> DATA.
- DATA:
  - Each accepted byte produces one write at the current address, then the address increments.
  - Adds the byte to an 8-bit running sum (mod 256).
  - After byte number len -> CHECK if the macro is defined, else FINISH ok.
- CHECK: accepts one byte; equal to sum -> FINISH ok, otherwise FINISH with error.
- FINISH (one cycle):
  - ok: done=1 and cpu_hold=0.
  - error: error=1 and cpu_hold stays 1.
  - Then -> IDLE.
- A rejected image leaves the already written bytes in the ROM. cpu_hold stays high so the CPU never runs a corrupt image.
- Further images may follow. Each header acceptance re-asserts cpu_hold until that image finishes.
- wr_bank holds its value from header latch until the next header; it is ignored outside wr_en.

## Timing
- Reset values:
  - in_ready=0, wr_en=0, wr_addr=0, wr_data=0, wr_bank=0.
  - cpu_hold=1, done=0, error=0.
  - State = IDLE.
- in_ready=1 in IDLE, LEN_LO, LEN_HI, DATA and CHECK; in_ready=0 in FINISH.
- Write latency:
  - wr_en, wr_addr and wr_data are registered and appear in the cycle after the DATA transfer.
  - Back-to-back transfers give back-to-back writes: one byte per clock sustained.
- Address wrap cannot occur: len is bounded by the bank depth. The last write goes to len-1.
- in_valid low stalls every state except FINISH. No timeouts.
- A reset during a load returns to IDLE in the next cycle and drops wr_en immediately. Partially written data stays in the ROM.
- done and error are never high together.

## Configuration
- ROM_LOADER_CHECKSUM_EN defined: the CHECK state exists and the stream carries a trailing checksum byte. A mismatch sets error.
- ROM_LOADER_CHECKSUM_EN undefined: there is no CHECK state and no sum register. The stream ends with the last data byte, and error arises only from a bad bank id or bad length.

## Structure
- A shared package c64_rom_pkg holds:
  - the bank id constants: BANK_BASIC=0, BANK_KERNAL=1, BANK_CHARGEN=2;
  - the FSM state enum;
  - the header field widths.
- Single module, no sub-modules.
- The ROM arrays gain a write port driven by wr_en & wr_bank[i]. That change lives in the ROM module, not here.

## Test plan
- Reset, then stream 01 00 20 followed by 8192 bytes of i&FF (plus checksum 00 when the macro is enabled):
  - 8192 writes to wr_bank=010, addresses 0..1FFF;
  - done=1, cpu_hold falls in the cycle after FINISH.
- Bank id 05:
  - error=1 after 3 cycles, no wr_en, cpu_hold stays 1;
  - a following valid image clears error.
- Header 00 00 00 (len 0) and 00 01 20 (len 2001h):
  - both give error=1 with no writes.
- With the macro: 02 04 00, bytes 01 02 03 04, then checksum 0B:
  - 4 writes to CHARGEN, error=1, done=0.
  - Repeating with checksum 0A gives done=1.
- in_valid toggled randomly during DATA:
  - writes occur only one cycle after each transfer;
  - wr_addr stays contiguous.
- Assert reset mid-DATA, after 100 bytes:
  - wr_en=0 and cpu_hold=1 in the next cycle;
  - a new header restarts at address 0.
